// File: rtl/ravenoc_pkg.sv
// rtl/ravenoc_pkg.sv - shared flit types, sizes and helpers for the ravenoc router
package ravenoc_pkg;

    localparam int FLIT_WIDTH     = 34;
    localparam int N_VC           = 2;
    localparam int MIN_SIZE_FLIT  = 1;
    localparam int X_W            = 2;
    localparam int Y_W            = 2;
    localparam int PKT_POS_WIDTH  = 8;
    localparam int MIN_DATA_WIDTH = FLIT_WIDTH - 2 - X_W - Y_W - PKT_POS_WIDTH;

    typedef enum logic [1:0] {
        HEAD_FLIT,
        BODY_FLIT,
        TAIL_FLIT
    } flit_type_t;

    typedef struct packed {
        flit_type_t                  type_f;
        logic [X_W-1:0]              x_dest;
        logic [Y_W-1:0]              y_dest;
        logic [PKT_POS_WIDTH-1:0]    pkt_size;
        logic [MIN_DATA_WIDTH-1:0]   data;
    } s_flit_head_data_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PEND,
        ST_LOCKED
    } arb_state_t;

    function automatic logic is_single_flit(input logic [FLIT_WIDTH-1:0] flit);
        s_flit_head_data_t head;
        head = s_flit_head_data_t'(flit);
        return (head.type_f == HEAD_FLIT) &&
               (head.pkt_size == PKT_POS_WIDTH'(MIN_SIZE_FLIT));
    endfunction

endpackage

// File: rtl/ravenoc_rr_arb.sv
// rtl/ravenoc_rr_arb.sv - combinational round-robin picker, first request at or after ptr
module ravenoc_rr_arb #(
    parameter int  N_IN  = 5,
    localparam int PTR_W = (N_IN > 1) ? $clog2(N_IN) : 1
) (
    input  logic [N_IN-1:0]  req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N_IN-1:0]  grant_o,
    output logic [PTR_W-1:0] idx_o,
    output logic             any_o
);

    always_comb begin
        int pos;
        logic [PTR_W-1:0] pos_idx;
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        pos     = 0;
        pos_idx = '0;
        // Walk upward from ptr with wrap; ptr is always kept below N_IN.
        for (int k = 0; k < N_IN; k++) begin
            pos = int'(ptr_i) + k;
            if (pos >= N_IN) begin
                pos = pos - N_IN;
            end
            pos_idx = PTR_W'(pos);
            if (!any_o && req_i[pos_idx]) begin
                any_o            = 1'b1;
                grant_o[pos_idx] = 1'b1;
                idx_o            = pos_idx;
            end
        end
    end

endmodule

// File: rtl/ravenoc_out_arb.sv
// rtl/ravenoc_out_arb.sv - wormhole output-port arbiter, round-robin on heads, locked until tail
module ravenoc_out_arb #(
    parameter int  N_IN       = 5,
    parameter int  FLIT_WIDTH = 34,
    parameter int  N_VC       = 2,
    localparam int VC_W       = (N_VC > 1) ? $clog2(N_VC) : 1,
    localparam int PTR_W      = (N_IN > 1) ? $clog2(N_IN) : 1
) (
    input  logic                            clk,
    input  logic                            arst,
    input  logic [N_IN-1:0]                 in_valid_i,
    input  logic [N_IN-1:0][FLIT_WIDTH-1:0] in_flit_i,
    input  logic [N_IN-1:0][VC_W-1:0]       in_vc_i,
    output logic [N_IN-1:0]                 in_ready_o,
    output logic                            out_valid_o,
    output logic [FLIT_WIDTH-1:0]           out_flit_o,
    output logic [VC_W-1:0]                 out_vc_o,
    input  logic                            out_ready_i,
    output logic [N_IN-1:0]                 grant_o,
    output logic                            lock_o,
    output logic                            err_o
);
    import ravenoc_pkg::*;

    arb_state_t             state_q, state_d;
    logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]       own_idx_q, own_idx_d;
    logic                   err_q, err_d;

    logic [N_IN-1:0]        head_req;
    logic [N_IN-1:0]        arb_grant;
    logic [PTR_W-1:0]       arb_idx;
    logic                   arb_any;

    logic [N_IN-1:0]        own_onehot;
    logic [N_IN-1:0]        grant_int;
    logic [PTR_W-1:0]       sel_idx;
    logic                   sel_valid;
    logic                   ready_gate;
    logic                   owner_head;
    logic [FLIT_WIDTH-1:0]  sel_flit;
    logic [1:0]             sel_type;
    logic                   sel_single;
    logic                   transfer;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(N_IN - 1)) ? '0 : p + 1'b1;
    endfunction

    for (genvar g = 0; g < N_IN; g++) begin : g_head_req
        assign head_req[g] = in_valid_i[g] &&
                             (in_flit_i[g][FLIT_WIDTH-1 -: 2] == HEAD_FLIT);
    end

    ravenoc_rr_arb #(
        .N_IN (N_IN)
    ) u_rr_arb (
        .req_i   (head_req),
        .ptr_i   (rr_ptr_q),
        .grant_o (arb_grant),
        .idx_o   (arb_idx),
        .any_o   (arb_any)
    );

    assign own_onehot = N_IN'(1) << own_idx_q;
    assign owner_head = in_valid_i[own_idx_q] &&
                        (in_flit_i[own_idx_q][FLIT_WIDTH-1 -: 2] == HEAD_FLIT);
    assign sel_flit   = in_flit_i[sel_idx];
    assign sel_type   = sel_flit[FLIT_WIDTH-1 -: 2];
    assign sel_single = is_single_flit(sel_flit);
    assign transfer   = sel_valid && out_ready_i;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q   <= ST_IDLE;
            rr_ptr_q  <= '0;
            own_idx_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            own_idx_q <= own_idx_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        own_idx_d = own_idx_q;
        err_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    own_idx_d = arb_idx;
                    if (!out_ready_i) begin
                        state_d = ST_PEND;
                    end else if (sel_single) begin
                        rr_ptr_d = ptr_inc(arb_idx);
                    end else begin
                        state_d = ST_LOCKED;
                    end
                end
            end
            ST_PEND: begin
                if (transfer) begin
                    if (sel_single) begin
                        state_d  = ST_IDLE;
                        rr_ptr_d = ptr_inc(own_idx_q);
                    end else begin
                        state_d = ST_LOCKED;
                    end
                end
            end
            ST_LOCKED: begin
                // A fresh head from the owner mid-packet is refused and flagged.
                err_d = owner_head;
                if (transfer && (sel_type == TAIL_FLIT)) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = ptr_inc(own_idx_q);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        sel_idx    = own_idx_q;
        grant_int  = '0;
        sel_valid  = 1'b0;
        ready_gate = 1'b1;
        case (state_q)
            ST_IDLE: begin
                sel_idx   = arb_idx;
                grant_int = arb_grant;
                sel_valid = arb_any;
            end
            ST_PEND: begin
                grant_int = own_onehot;
                sel_valid = in_valid_i[own_idx_q];
            end
            ST_LOCKED: begin
                grant_int  = own_onehot;
                sel_valid  = in_valid_i[own_idx_q] && !owner_head;
                ready_gate = !owner_head;
            end
            default: ;
        endcase
    end

    assign grant_o     = arst ? '0 : grant_int;
    assign in_ready_o  = (arst || !out_ready_i || !ready_gate) ? '0 : grant_int;
    assign out_valid_o = !arst && sel_valid;
    assign out_flit_o  = (arst || (grant_int == '0)) ? '0 : sel_flit;
    assign out_vc_o    = (arst || (grant_int == '0)) ? '0 : in_vc_i[sel_idx];
    assign lock_o      = !arst && (state_q == ST_LOCKED);
    assign err_o       = !arst && err_q;

endmodule
